// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, free-running oversample tick, start-bit
// qualification, mid-bit sampling of 8N1 frames, one-cycle valid/error strobes.
module uart_rx #(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned S_W      = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           sync_q, sync_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [S_W-1:0]       s_cnt_q, s_cnt_d;
   logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 busy_q, busy_d;
   logic                 tick_c;
   logic                 rxd_s;
   logic                 mid_start_c;
   logic                 bit_end_c;

   assign rxd_s       = sync_q[1];
   assign tick_c      = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
   assign mid_start_c = (s_cnt_q == S_W'(OVERSAMPLE / 2 - 1));
   assign bit_end_c   = (s_cnt_q == S_W'(OVERSAMPLE - 1));

   // Synchroniser and free-running tick divider; the tick is never realigned to edges.
   always_comb begin
      sync_d     = {sync_q[0], rxd};
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
   end

   // State register plus datapath and output registers; synchroniser resets to idle-high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         sync_q       <= 2'b11;
         tick_cnt_q   <= '0;
         s_cnt_q      <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         tick_cnt_q   <= tick_cnt_d;
         s_cnt_q      <= s_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic: every transition and counter step happens on a tick only.
   always_comb begin
      state_d   = state_q;
      s_cnt_d   = s_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      if (tick_c) begin
         unique case (state_q)
            IDLE: begin
               if (!rxd_s) begin
                  state_d = START;
                  s_cnt_d = '0;
               end
            end
            START: begin
               if (mid_start_c) begin
                  s_cnt_d = '0;
                  if (rxd_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d   = DATA;
                     bit_idx_d = '0;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + S_W'(1);
               end
            end
            DATA: begin
               if (bit_end_c) begin
                  s_cnt_d   = '0;
                  shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                  bit_idx_d = bit_idx_q + BIT_W'(1);
                  if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                     state_d = STOP;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + S_W'(1);
               end
            end
            STOP: begin
               if (bit_end_c) begin
                  s_cnt_d = '0;
                  state_d = IDLE;
               end else begin
                  s_cnt_d = s_cnt_q + S_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output logic: strobes and data update at the mid-stop-bit sample; busy tracks the state.
   always_comb begin
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      data_out_d   = data_out_q;
      busy_d       = (state_d != IDLE);
      if (tick_c && (state_q == STOP) && bit_end_c) begin
         if (rxd_s) begin
            data_valid_d = 1'b1;
            data_out_d   = shift_q;
         end else begin
            frame_err_d  = 1'b1;
         end
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Baud is scaled up so a bit is 96 clk (TICK_DIV=6,
// truncated from 6.25) to keep the run short; the frame timing is otherwise identical.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 100_000_000;
   localparam int unsigned BAUD     = 1_000_000;
   localparam int unsigned OS       = 16;
   localparam int unsigned TICK     = 6;
   localparam int unsigned BIT      = OS * TICK;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   int total = 0;
   int bad   = 0;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .OVERSAMPLE(OS),
      .DATA_BITS (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .data_out  (data_out),
      .data_valid(data_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Strobe monitor
   int         valid_cnt   = 0;
   int         err_cnt     = 0;
   int         overlap_cnt = 0;
   int         consec_cnt  = 0;
   longint     cyc         = 0;
   logic       prev_strobe = 1'b0;
   logic [7:0] cap_data[$];
   longint     vtime[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (data_valid === 1'b1) begin
         valid_cnt = valid_cnt + 1;
         cap_data.push_back(data_out);
         vtime.push_back(cyc);
      end
      if (frame_err === 1'b1) err_cnt = err_cnt + 1;
      if (data_valid === 1'b1 && frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
      if ((data_valid === 1'b1 || frame_err === 1'b1) && prev_strobe) consec_cnt = consec_cnt + 1;
      prev_strobe = (data_valid === 1'b1) || (frame_err === 1'b1);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      clks(BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic chk_busy);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (chk_busy && i == 1) begin
            rxd = d[i];
            clks(BIT / 2);
            check("busy_mid_frame", 32'(busy), 32'd1);
            clks(BIT / 2 - 1);
         end else begin
            send_bit(d[i]);
         end
      end
      send_bit(stop);
      rxd = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_v;
      int         exp_e;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int v0, e0, idx;
      longint dt;

      vecs[0] = '{8'h3C, 1'b0, 0, 1, 8'h0F};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
      vecs[4] = '{8'hC5, 1'b1, 1, 0, 8'hC5};

      // 1. reset and idle line
      rst = 1'b0;
      rxd = 1'b1;
      clks(4);
      settle();
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      clks(2 * BIT);
      settle();
      check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
      check("idle_err_cnt", 32'(err_cnt), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // 2. single frame 0x55
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(8'h55, 1'b1, 1'b1);
      clks(BIT);
      settle();
      check("f55_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check("f55_err_cnt", 32'(err_cnt - e0), 32'd0);
      check("f55_data_out", 32'(data_out), 32'h55);
      check("f55_busy_after", 32'(busy), 32'd0);

      // 3. back-to-back 0xA3, 0x0F
      v0  = valid_cnt;
      e0  = err_cnt;
      idx = vtime.size();
      send_frame(8'hA3, 1'b1, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0);
      clks(BIT);
      settle();
      check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      check("b2b_err_cnt", 32'(err_cnt - e0), 32'd0);
      if (vtime.size() >= idx + 2) begin
         check("b2b_first", 32'(cap_data[idx]), 32'hA3);
         check("b2b_second", 32'(cap_data[idx + 1]), 32'h0F);
         dt = vtime[idx + 1] - vtime[idx];
         check("b2b_spacing_ok", (dt >= longint'(10 * BIT - TICK) && dt <= longint'(10 * BIT + TICK)) ? 32'd1 : 32'd0, 32'd1);
      end
      check("b2b_data_out", 32'(data_out), 32'h0F);

      // 4. start glitch of 3 ticks
      v0  = valid_cnt;
      e0  = err_cnt;
      rxd = 1'b0;
      clks(2 * TICK);
      settle();
      check("glitch_busy_high", 32'(busy), 32'd1);
      clks(TICK);
      rxd = 1'b1;
      clks(8 * TICK);
      settle();
      check("glitch_busy_low", 32'(busy), 32'd0);
      check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check("glitch_err_cnt", 32'(err_cnt - e0), 32'd0);

      // 5. table: stop-bit errors and good frames
      for (int k = 0; k < 5; k++) begin
         v0 = valid_cnt;
         e0 = err_cnt;
         send_frame(vecs[k].data, vecs[k].stop, 1'b0);
         clks(2 * BIT);
         settle();
         check($sformatf("vec%0d_valid_cnt", k), 32'(valid_cnt - v0), 32'(vecs[k].exp_v));
         check($sformatf("vec%0d_err_cnt", k), 32'(err_cnt - e0), 32'(vecs[k].exp_e));
         check($sformatf("vec%0d_data_out", k), 32'(data_out), 32'(vecs[k].exp_out));
         check($sformatf("vec%0d_busy", k), 32'(busy), 32'd0);
      end

      // 6. reset in the middle of data bit 4, then a clean 0x81
      v0 = valid_cnt;
      e0 = err_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rxd = 1'b1;
      clks(BIT / 2);
      rst = 1'b0;
      clks(1);
      rst = 1'b1;
      settle();
      check("abort_data_out", 32'(data_out), 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      clks(2 * BIT);
      settle();
      check("abort_valid_cnt", 32'(valid_cnt - v0), 32'd0);
      check("abort_err_cnt", 32'(err_cnt - e0), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0);
      clks(BIT);
      settle();
      check("f81_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      check("f81_data_out", 32'(data_out), 32'h81);
      check("f81_err_cnt", 32'(err_cnt - e0), 32'd0);

      check("strobe_overlap", 32'(overlap_cnt), 32'd0);
      check("strobe_consecutive", 32'(consec_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
